// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - opcode constants, state encoding and opcode classing shared by sequencer, datapath and benches
package cpu_defs;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_e;

  // Execute-phase shape of an instruction; drives the T3..T6 walk
  typedef enum logic [2:0] {
    CLS_3R, CLS_UN, CLS_MD, CLS_NOP, CLS_HALT, CLS_ILL
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:        return CLS_3R;
      OP_NEG, OP_NOT:                         return CLS_UN;
      OP_MUL, OP_DIV:                         return CLS_MD;
      OP_NOP:                                 return CLS_NOP;
      OP_HALT:                                return CLS_HALT;
      default:                                return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/select_encode.sv
// rtl/select_encode.sv - picks Ra/Rb/Rc and turns it into one-hot register load/drive enables
module select_encode (
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  input  logic        gra,
  input  logic        grb,
  input  logic        grc,
  input  logic        rin_en,
  input  logic        rout_en,
  output logic [15:0] rin,
  output logic [15:0] rout
);

  logic [3:0]  sel;
  logic [15:0] dec;

  // Priority pick of the register field, then one-hot decode gated by the enables
  always_comb begin
    sel = 4'd0;
    dec = 16'd0;
    if (gra)      sel = ra;
    else if (grb) sel = rb;
    else          sel = rc;
    if (gra || grb || grc) dec = 16'd1 << sel;
    rin  = rin_en  ? dec : 16'd0;
    rout = rout_en ? dec : 16'd0;
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore control FSM: fetch, decode and execute strobes for the datapath
module control_sequencer
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        MemDone,
  input  logic        Stop,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        Run,
  output logic        Illegal
);

  state_e    state, state_nx, end_nx;
  logic [16:0] ir_q;
  logic      halt_wait;
  logic [4:0] op_q;
  op_class_e cls;
  logic      gra, grb, grc, rin_en, rout_en, alu_en;
  logic      unused_ir;

  assign op_q      = ir_q[16:12];
  assign cls       = op_class(op_q);
  assign unused_ir = ^IR[14:0];

  // State register; reset forces RST from anywhere
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RST;
    else        state <= state_nx;
  end

  // Latch the instruction fields as the datapath loads IR, and remember an opcode halt needs a Stop pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir_q      <= '0;
      halt_wait <= 1'b0;
    end else begin
      if (state == ST_T2) ir_q <= IR[31:15];
      if (state == ST_T3 && cls == CLS_HALT) halt_wait <= 1'b1;
      else if (state == ST_HALT && Stop)     halt_wait <= 1'b0;
    end
  end

  // Next-state walk; Stop is only honoured on the final step of an instruction
  always_comb begin
    end_nx   = Stop ? ST_HALT : ST_T0;
    state_nx = state;
    case (state)
      ST_RST:  state_nx = end_nx;
      ST_T0:   state_nx = ST_T1;
      ST_T1:   state_nx = MemDone ? ST_T2 : ST_T1;
      ST_T2:   state_nx = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_3R, CLS_UN, CLS_MD: state_nx = ST_T4;
          CLS_HALT:               state_nx = ST_HALT;
          default:                state_nx = end_nx;
        endcase
      end
      ST_T4:   state_nx = (cls == CLS_UN) ? end_nx : ST_T5;
      ST_T5:   state_nx = (cls == CLS_MD) ? ST_T6 : end_nx;
      ST_T6:   state_nx = end_nx;
      ST_HALT: state_nx = (!halt_wait && !Stop) ? ST_T0 : ST_HALT;
      default: state_nx = ST_RST;
    endcase
  end

  // Strobe decode from state and latched opcode only
  always_comb begin
    {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
    {Yin, Zin, Zlowout, Zhighout, HIin, LOin}              = '0;
    {gra, grb, grc, rin_en, rout_en, alu_en}               = '0;
    Illegal = 1'b0;
    Run     = (state != ST_RST) && (state != ST_HALT);
    case (state)
      ST_T0: {PCout, MARin, IncPC, PCin} = 4'hF;
      ST_T1: {Read, MDRin} = 2'b11;
      ST_T2: {MDRout, IRin} = 2'b11;
      ST_T3: begin
        case (cls)
          CLS_3R:  begin grb = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
          CLS_UN:  begin grb = 1'b1; rout_en = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
          CLS_MD:  begin gra = 1'b1; rout_en = 1'b1; Yin = 1'b1; end
          CLS_ILL: Illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_3R:  begin grc = 1'b1; rout_en = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
          CLS_UN:  begin gra = 1'b1; rin_en = 1'b1; Zlowout = 1'b1; end
          CLS_MD:  begin grb = 1'b1; rout_en = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        if (cls == CLS_MD) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else begin
          gra = 1'b1; rin_en = 1'b1; Zlowout = 1'b1;
        end
      end
      ST_T6: {Zhighout, HIin} = 2'b11;
      default: ;
    endcase
    AND  = alu_en && (op_q == OP_AND);
    OR   = alu_en && (op_q == OP_OR);
    ADD  = alu_en && (op_q == OP_ADD);
    SUB  = alu_en && (op_q == OP_SUB);
    MUL  = alu_en && (op_q == OP_MUL);
    DIV  = alu_en && (op_q == OP_DIV);
    SHR  = alu_en && (op_q == OP_SHR);
    SHRA = alu_en && (op_q == OP_SHRA);
    SHL  = alu_en && (op_q == OP_SHL);
    ROR  = alu_en && (op_q == OP_ROR);
    ROL  = alu_en && (op_q == OP_ROL);
    NEG  = alu_en && (op_q == OP_NEG);
    NOT  = alu_en && (op_q == OP_NOT);
  end

  select_encode u_select_encode (
    .ra      (ir_q[11:8]),
    .rb      (ir_q[7:4]),
    .rc      (ir_q[3:0]),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin_en  (rin_en),
    .rout_en (rout_en),
    .rin     (Rin),
    .rout    (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench: per-cycle expected strobes from an instruction-level model
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, MemDone, Stop;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic [15:0] Rin, Rout;
  logic Run, Illegal;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR(IR), .MemDone(MemDone), .Stop(Stop),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .Rin(Rin), .Rout(Rout), .Run(Run), .Illegal(Illegal)
  );

  typedef struct packed {
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [12:0] alu;   // AND OR ADD SUB MUL DIV SHR SHRA SHL ROR ROL NEG NOT
    logic [15:0] rin;
    logic [15:0] rout;
    logic run;
    logic ill;
  } ov_t;

  ov_t obs;
  assign obs = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
                Rin, Rout, Run, Illegal};

  ov_t   exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;
  ov_t   mon_e;
  string mon_t;

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (obs !== mon_e) begin
        errors++;
        $display("FAIL %s got %h want %h", mon_t, obs, mon_e);
      end
    end
  end

  // ALU strobe position for an opcode, counted from the NOT end
  function automatic int alu_bit(input logic [4:0] op);
    case (op)
      5'd5:  return 12;
      5'd6:  return 11;
      5'd3:  return 10;
      5'd4:  return 9;
      5'd15: return 8;
      5'd16: return 7;
      5'd9:  return 6;
      5'd10: return 5;
      5'd11: return 4;
      5'd7:  return 3;
      5'd8:  return 2;
      5'd17: return 1;
      5'd18: return 0;
      default: return -1;
    endcase
  endfunction

  // One clock: drive inputs, record what this cycle must show
  task automatic step(input ov_t e, input string tag, input logic rst, input logic md, input logic stp);
    reset   = rst;
    MemDone = md;
    Stop    = stp;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // HALT entered with no opcode-halt pending: m cycles of Stop high, then release
  task automatic halt_release(input int m, input string tag);
    for (int i = 0; i < m; i++) step('0, {tag, " halt"}, 1'b1, 1'($urandom), 1'b1);
    step('0, {tag, " halt rel"}, 1'b1, 1'($urandom), 1'b0);
  endtask

  task automatic run_instr(input logic [31:0] ir, input int k, input logic stp_last,
                           input int abort_at, input int n);
    ov_t e, base;
    ov_t ex[$];
    logic [4:0] op;
    logic [15:0] ra_h, rb_h, rc_h;
    logic [12:0] alu_h;
    logic halt_op, last, stp;
    string tg;
    op    = ir[31:27];
    ra_h  = 16'd1 << ir[26:23];
    rb_h  = 16'd1 << ir[22:19];
    rc_h  = 16'd1 << ir[18:15];
    alu_h = (alu_bit(op) >= 0) ? (13'd1 << alu_bit(op)) : 13'd0;
    halt_op = (op == 5'd27);
    tg = $sformatf("i%0d op%0d", n, op);
    IR = ir;
    base = '0;
    base.run = 1'b1;

    e = base; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.PCin = 1;
    step(e, {tg, " T0"}, 1'b1, 1'($urandom), 1'($urandom));
    e = base; e.Read = 1; e.MDRin = 1;
    for (int i = 0; i <= k; i++) step(e, {tg, " T1"}, 1'b1, (i == k), 1'($urandom));
    e = base; e.MDRout = 1; e.IRin = 1;
    step(e, {tg, " T2"}, 1'b1, 1'($urandom), 1'($urandom));

    if (op >= 5'd3 && op <= 5'd11) begin
      e = base; e.rout = rb_h; e.Yin = 1; ex.push_back(e);
      e = base; e.rout = rc_h; e.alu = alu_h; e.Zin = 1; ex.push_back(e);
      e = base; e.Zlowout = 1; e.rin = ra_h; ex.push_back(e);
    end else if (op == 5'd17 || op == 5'd18) begin
      e = base; e.rout = rb_h; e.alu = alu_h; e.Zin = 1; ex.push_back(e);
      e = base; e.Zlowout = 1; e.rin = ra_h; ex.push_back(e);
    end else if (op == 5'd15 || op == 5'd16) begin
      e = base; e.rout = ra_h; e.Yin = 1; ex.push_back(e);
      e = base; e.rout = rb_h; e.alu = alu_h; e.Zin = 1; ex.push_back(e);
      e = base; e.Zlowout = 1; e.LOin = 1; ex.push_back(e);
      e = base; e.Zhighout = 1; e.HIin = 1; ex.push_back(e);
    end else if (op == 5'd26 || halt_op) begin
      ex.push_back(base);
    end else begin
      e = base; e.ill = 1; ex.push_back(e);
    end

    for (int j = 0; j < ex.size(); j++) begin
      last = (j == ex.size() - 1);
      if (j == abort_at) begin
        step(ex[j], $sformatf("%s T%0d abort", tg, j + 3), 1'b0, 1'($urandom), 1'($urandom));
        stp = 1'($urandom);
        step('0, {tg, " rst"}, 1'b1, 1'($urandom), stp);
        if (stp) halt_release($urandom_range(0, 2), tg);
        return;
      end
      stp = last ? (halt_op ? 1'($urandom) : stp_last) : 1'($urandom);
      step(ex[j], $sformatf("%s T%0d", tg, j + 3), 1'b1, 1'($urandom), stp);
    end

    if (halt_op) begin
      int a = $urandom_range(0, 2);
      int b = $urandom_range(1, 2);
      for (int i = 0; i < a; i++) step('0, {tg, " hwait"}, 1'b1, 1'($urandom), 1'b0);
      for (int i = 0; i < b; i++) step('0, {tg, " hstop"}, 1'b1, 1'($urandom), 1'b1);
      step('0, {tg, " hrel"}, 1'b1, 1'($urandom), 1'b0);
    end else if (stp_last) begin
      halt_release($urandom_range(0, 2), tg);
    end
  endtask

  logic [4:0] legal_ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};

  initial begin
    logic [4:0] op;
    reset = 1'b0; MemDone = 1'b0; Stop = 1'b0; IR = '0;
    @(posedge clk);
    #1;
    step('0, "rst hold", 1'b0, 1'b1, 1'b0);
    step('0, "rst hold2", 1'b0, 1'b0, 1'b1);
    step('0, "rst exit", 1'b1, 1'b0, 1'b0);

    run_instr(32'h2A2B8000, 0, 1'b0, -1, 0);            // AND R4,R5,R7
    run_instr(32'h79880000, 0, 1'b0, -1, 1);            // MUL R3,R1
    run_instr(32'h1A2B8000, 3, 1'b0, -1, 2);            // ADD with 3-cycle memory wait
    run_instr(32'hF8000000, 0, 1'b0, -1, 3);            // opcode 31
    run_instr(32'h1A2B8000, 1, 1'b1, -1, 4);            // ADD, Stop on last step
    run_instr(32'h22AB8000, 0, 1'b0, 1, 5);             // SUB, reset at T4
    run_instr({5'd27, 27'd0}, 0, 1'b0, -1, 6);          // HALT opcode
    run_instr({5'd26, 27'h5A5A5A5}, 2, 1'b0, -1, 7);    // NOP
    run_instr({5'd17, 4'd0, 4'd15, 19'd0}, 0, 1'b0, -1, 8);
    run_instr({5'd16, 4'd15, 4'd0, 19'd0}, 0, 1'b1, -1, 9);

    for (int n = 10; n < 310; n++) begin
      if ($urandom_range(0, 1) == 0) op = 5'($urandom_range(0, 31));
      else                           op = legal_ops[$urandom_range(0, 14)];
      run_instr({op, 27'($urandom)}, $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1, n);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-003 SHALL have port: IR  in  32  instruction register contents from datapath; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-004 SHALL have port: MemDone  in  1  memory read complete.
REQ-005 SHALL have port: Stop  in  1  halt request.
REQ-006 SHALL have ports: PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes.
REQ-007 SHALL have ports: Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  execute strobes.
REQ-008 SHALL have ports: AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  out  1 each  ALU op select; at most one high.
REQ-009 SHALL have ports: Rin, Rout  out  16 each  one-hot general-register load and drive enables; bit n maps to Rn.
REQ-010 SHALL have ports: Run  out  1  high while sequencing; Illegal  out  1  one-cycle undefined-opcode pulse.

Function
REQ-011 SHALL be a Moore FSM: every output a decode of the state register and latched IR fields only.
REQ-012 SHALL use states RST, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-013 Fetch:
- T0: PCout, MARin, IncPC, PCin.
- T1: Read, MDRin.
- T2: MDRout, IRin.
REQ-014 T1 SHALL hold while MemDone=0; it advances to T2 on the first edge with MemDone=1. Read and MDRin SHALL stay high throughout.
REQ-015 Opcodes (decimal): ADD 3, SUB 4, AND 5, OR 6, ROR 7, ROL 8, SHR 9, SHRA 10, SHL 11, MUL 15, DIV 16, NEG 17, NOT 18, NOP 26, HALT 27.
REQ-016 Decode at T3 SHALL use IR as loaded at T2.
REQ-017 Three-register ops (3-11):
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], op strobe, Zin.
- T5: Zlowout, Rin[Ra].
- Then T0.
REQ-018 NEG/NOT:
- T3: Rout[Rb], op strobe, Zin.
- T4: Zlowout, Rin[Ra].
- Then T0.
REQ-019 MUL/DIV:
- T3: Rout[Ra], Yin.
- T4: Rout[Rb], op strobe, Zin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then T0.
REQ-020 NOP: T3 SHALL assert no strobes and return to T0.
REQ-021 HALT opcode: T3 SHALL go to HALT.
REQ-022 Any other opcode SHALL pulse Illegal for the T3 cycle only, then go to T0; PC is not restored.
REQ-023 Stop=1 sampled on the last step of an instruction SHALL enter HALT instead of T0; Stop never aborts an instruction mid-way.
REQ-024 HALT: Run=0, all strobes 0; Stop=0 resumes at T0 next edge (HALT opcode also needs Stop pulse high then low).
REQ-025 Rin/Rout SHALL have at most one bit set, only in the steps listed; R0 is treated as an ordinary register.

Reset
REQ-026 reset=0 at an edge SHALL force RST from any state, including mid-instruction or mid-T1 wait.
REQ-027 In RST every output SHALL be 0, including Run and Illegal.
REQ-028 The first edge with reset=1 SHALL enter T0 (Run=1), or HALT if Stop=1.

Structure
REQ-029 Opcode constants and state encodings SHALL live in a shared package cpu_defs used by datapath and benches.
REQ-030 One sub-module select_encode SHALL map (IR fields, Gra/Grb/Grc, Rin_en/Rout_en) to the 16-bit one-hot Rin/Rout.

Verification
REQ-031 IR=0x2A2B8000 (AND R4,R5,R7), MemDone=1 -> T3 Rout=0x0020, Yin; T4 Rout=0x0080, AND, Zin; T5 Zlowout, Rin=0x0010; 6 cycles T0->T0.
REQ-032 IR=0x79880000 (MUL R3,R1) -> T3 Rout=0x0008; T4 Rout=0x0002, MUL; T5 Zlowout+LOin; T6 Zhighout+HIin; 7 cycles.
REQ-033 MemDone low 3 cycles in T1 -> Read and MDRin high for 4 consecutive cycles, IRin only after.
REQ-034 IR=0xF8000000 (opcode 31) -> Illegal=1 for exactly 1 cycle, next state T0, no Rin bit set.
REQ-035 Stop=1 raised at T4 of ADD -> T5 completes (Rin[Ra] asserted), then HALT, Run=0; Stop=0 -> T0.
REQ-036 reset=0 during T4 of SUB -> all outputs 0 after that edge; reset=1 -> T0 next edge.
